// File: rtl/mult_seq_fsm.sv
// Step sequencer for an A_W x B_W multiply built from one A_CW x B_CW partial-product unit.
// Walks the (ai, bi) chunk grid, optionally skipping steps above the low result half.
module mult_seq_fsm #(
    parameter int A_W  = 32,
    parameter int B_W  = 32,
    parameter int A_CW = 8,
    parameter int B_CW = 16,
    parameter int LO_W = 32
) (
    input  logic                                                  clk,
    input  logic                                                  rst,
    input  logic                                                  start,
    input  logic                                                  mode,
    input  logic                                                  abort,
    input  logic                                                  ack,
    output logic                                                  ready,
    output logic                                                  busy,
    output logic                                                  valid,
    output logic [((A_W / A_CW) > 1 ? $clog2(A_W / A_CW) : 1)-1:0] a_sel,
    output logic [((B_W / B_CW) > 1 ? $clog2(B_W / B_CW) : 1)-1:0] b_sel,
    output logic [$clog2(A_W + B_W)-1:0]                          shift_val,
    output logic                                                  upd_prod,
    output logic                                                  clr_prod
);

    localparam int NA   = A_W / A_CW;
    localparam int NB   = B_W / B_CW;
    localparam int AI_W = (NA > 1) ? $clog2(NA) : 1;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam int SH_W = $clog2(A_W + B_W);

    if ((A_W % A_CW) != 0) begin : g_chk_a
        $error("mult_seq_fsm: A_W must be a multiple of A_CW");
    end
    if ((B_W % B_CW) != 0) begin : g_chk_b
        $error("mult_seq_fsm: B_W must be a multiple of B_CW");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [AI_W-1:0] ai_q, ai_d;
    logic [BI_W-1:0] bi_q, bi_d;
    logic            mode_q, mode_d;

    int              nxt_ai;
    int              nxt_bi;
    logic            nxt_end;
    logic            ready_raw;

    function automatic int step_shift(input int a, input int b);
        return a * A_CW + b * B_CW;
    endfunction

    function automatic logic step_skipped(input logic m, input int a, input int b);
        return !m && (step_shift(a, b) >= LO_W);
    endfunction

    // Next non-skipped step. Shifts grow with ai inside a row and with bi down
    // column 0, so once a step is skipped only the start of the next row can survive.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        nxt_ai  = 0;
        nxt_bi  = 0;
        nxt_end = 1'b0;
        if (int'(ai_q) < NA - 1) begin
            nxt_ai = int'(ai_q) + 1;
            nxt_bi = int'(bi_q);
        end else if (int'(bi_q) < NB - 1) begin
            nxt_ai = 0;
            nxt_bi = int'(bi_q) + 1;
        end else begin
            nxt_end = 1'b1;
        end
        if (!nxt_end && step_skipped(mode_q, nxt_ai, nxt_bi)) begin
            if (nxt_ai != 0 && nxt_bi < NB - 1 && !step_skipped(mode_q, 0, nxt_bi + 1)) begin
                nxt_ai = 0;
                nxt_bi = nxt_bi + 1;
            end else begin
                nxt_end = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ai_d      = ai_q;
        bi_d      = bi_q;
        mode_d    = mode_q;
        ready_raw = 1'b0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        ready     = 1'b0;

        case (state_q)
            S_IDLE: ready_raw = 1'b1;
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ai_d    = '0;
                    bi_d    = '0;
                end else begin
                    upd_prod = rst;
                    if (nxt_end) begin
                        state_d = S_DONE;
                        ai_d    = '0;
                        bi_d    = '0;
                    end else begin
                        ai_d = AI_W'(nxt_ai);
                        bi_d = BI_W'(nxt_bi);
                    end
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    ai_d    = '0;
                    bi_d    = '0;
                end else if (ack) begin
                    ready_raw = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                ai_d    = '0;
                bi_d    = '0;
            end
        endcase

        // Abort already suppressed ready_raw above, so it also wins over start.
        ready = rst && ready_raw;
        if (start && ready) begin
            clr_prod = 1'b1;
            mode_d   = mode;
            ai_d     = '0;
            bi_d     = '0;
            state_d  = S_RUN;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q <= S_IDLE;
            ai_q    <= '0;
            bi_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ai_q    <= ai_d;
            bi_q    <= bi_d;
            mode_q  <= mode_d;
        end
    end

    assign busy      = (state_q == S_RUN);
    assign valid     = (state_q == S_DONE);
    assign a_sel     = ai_q;
    assign b_sel     = bi_q;
    assign shift_val = SH_W'(step_shift(int'(ai_q), int'(bi_q)));

endmodule

// File: tb/tb_mult_seq_fsm.sv
// Scoreboard bench for mult_seq_fsm: default configuration plus a 16x16 / 8x8 instance.
module tb_mult_seq_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, sel, start, mode, abort, ack;

    logic start0, mode0, abort0, ack0, start1, mode1, abort1, ack1;
    assign start0 = start & ~sel;
    assign abort0 = abort & ~sel;
    assign ack0   = ack & ~sel;
    assign mode0  = mode;
    assign start1 = start & sel;
    assign abort1 = abort & sel;
    assign ack1   = ack & sel;
    assign mode1  = mode;

    logic       ready0, busy0, valid0, upd0, clr0;
    logic [1:0] a0;
    logic [0:0] b0;
    logic [5:0] sh0;
    logic       ready1, busy1, valid1, upd1, clr1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic [4:0] sh1;

    mult_seq_fsm dut0 (
        .clk(clk), .rst(rst), .start(start0), .mode(mode0), .abort(abort0), .ack(ack0),
        .ready(ready0), .busy(busy0), .valid(valid0), .a_sel(a0), .b_sel(b0),
        .shift_val(sh0), .upd_prod(upd0), .clr_prod(clr0)
    );

    mult_seq_fsm #(.A_W(16), .B_W(16), .A_CW(8), .B_CW(8), .LO_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode1), .abort(abort1), .ack(ack1),
        .ready(ready1), .busy(busy1), .valid(valid1), .a_sel(a1), .b_sel(b1),
        .shift_val(sh1), .upd_prod(upd1), .clr_prod(clr1)
    );

    logic ready_s, busy_s, valid_s, upd_s, clr_s;
    int   a_s, b_s;
    always_comb begin
        ready_s = sel ? ready1 : ready0;
        busy_s  = sel ? busy1  : busy0;
        valid_s = sel ? valid1 : valid0;
        upd_s   = sel ? upd1   : upd0;
        clr_s   = sel ? clr1   : clr0;
        a_s     = sel ? int'(a1) : int'(a0);
        b_s     = sel ? int'(b1) : int'(b0);
    end

    typedef struct {
        bit done;
        int a;
        int b;
        int sh;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: DUT event not predicted by the model at %0t", name, $time);
    endtask

    // Reference model: enumerate the chunk grid (B outer, A inner) and keep the
    // steps whose shift lands inside the requested result range.
    task automatic push_op(input bit m, output int s);
        int   acw, bcw, na, nb, low;
        exp_t e;
        if (sel) begin
            acw = 8; bcw = 8; na = 2; nb = 2; low = 16;
        end else begin
            acw = 8; bcw = 16; na = 4; nb = 2; low = 32;
        end
        s = 0;
        for (int b = 0; b < nb; b++) begin
            for (int a = 0; a < na; a++) begin
                e.done = 1'b0; e.a = a; e.b = b; e.sh = a * acw + b * bcw;
                if (m || e.sh < low) begin
                    if (sel) q1.push_back(e); else q0.push_back(e);
                    s++;
                end
            end
        end
        e.done = 1'b1; e.a = 0; e.b = 0; e.sh = 0;
        if (sel) q1.push_back(e); else q0.push_back(e);
    endtask

    function automatic int q_size(input int w);
        return (w != 0) ? q1.size() : q0.size();
    endfunction

    function automatic exp_t pop_q(input int w);
        if (w != 0) return q1.pop_front();
        return q0.pop_front();
    endfunction

    task automatic mon(input int w, input logic bsy, input logic upd, input logic ab,
                       input logic vld, input logic vprev, input int a, input int b, input int sh);
        exp_t e;
        if (bsy) begin
            if (ab) begin
                check($sformatf("dut%0d_upd_on_abort", w), int'(upd), 0);
            end else if (!upd) begin
                note_fail($sformatf("dut%0d_run_without_upd", w));
            end else if (q_size(w) == 0) begin
                note_fail($sformatf("dut%0d_unexpected_step", w));
            end else begin
                e = pop_q(w);
                check($sformatf("dut%0d_step_before_done", w), int'(e.done), 0);
                check($sformatf("dut%0d_a_sel", w), a, e.a);
                check($sformatf("dut%0d_b_sel", w), b, e.b);
                check($sformatf("dut%0d_shift_val", w), sh, e.sh);
            end
        end
        if (vld && !vprev) begin
            if (q_size(w) == 0) begin
                note_fail($sformatf("dut%0d_unexpected_valid", w));
            end else begin
                e = pop_q(w);
                check($sformatf("dut%0d_valid_after_last_step", w), int'(e.done), 1);
            end
        end
    endtask

    logic vp0 = 1'b0;
    logic vp1 = 1'b0;
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            mon(0, busy0, upd0, abort0, valid0, vp0, int'(a0), int'(b0), int'(sh0));
            mon(1, busy1, upd1, abort1, valid1, vp1, int'(a1), int'(b1), int'(sh1));
            vp0 <= valid0;
            vp1 <= valid1;
        end else begin
            vp0 <= 1'b0;
            vp1 <= 1'b0;
        end
    end

    // Called at posedge+1 of the accept cycle; returns at posedge+2 of it.
    task automatic issue(input bit m, output int s);
        start = 1'b1;
        mode  = m;
        push_op(m, s);
        #1;
        check("clr_on_accept", int'(clr_s), 1);
        check("ready_on_accept", int'(ready_s), 1);
    endtask

    task automatic run_to_valid(input int exp_lat);
        int lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            ack   = 1'b0;
            lat++;
        end while (valid_s !== 1'b1 && lat < 40);
        check("latency_to_valid", lat, exp_lat);
    endtask

    task automatic abort_at(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ack   = 1'b0;
        end
        abort = 1'b1;
        ack   = 1'b1;
        start = 1'b1;
        #1;
        check("abort_cycle_upd", int'(upd_s), 0);
        check("abort_cycle_clr", int'(clr_s), 0);
        check("abort_cycle_ready", int'(ready_s), 0);
        @(posedge clk); #1;
        abort = 1'b0;
        ack   = 1'b0;
        start = 1'b0;
        if (sel) q1.delete(); else q0.delete();
        check("after_abort_busy", int'(busy_s), 0);
        check("after_abort_valid", int'(valid_s), 0);
        check("after_abort_a_sel", a_s, 0);
        check("after_abort_b_sel", b_s, 0);
        check("after_abort_ready", int'(ready_s), 1);
    endtask

    task automatic ack_to_idle();
        ack   = 1'b1;
        start = 1'b0;
        #1;
        check("ready_on_ack", int'(ready_s), 1);
        @(posedge clk); #1;
        ack = 1'b0;
        check("valid_cleared_by_ack", int'(valid_s), 0);
        check("idle_after_ack", int'(busy_s), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  s;
        bit  have_op;

        rst = 1'b0; sel = 1'b0; start = 1'b1; mode = 1'b1; abort = 1'b0; ack = 1'b0;
        #2;
        check("reset_ready_pre_edge", int'(ready0), 0);
        check("reset_clr_pre_edge", int'(clr0), 0);
        @(posedge clk); #1;
        check("reset_ready", int'(ready0), 0);
        check("reset_clr", int'(clr0), 0);
        check("reset_busy", int'(busy0), 0);
        check("reset_valid", int'(valid0), 0);
        check("reset_upd", int'(upd0), 0);
        check("reset_a_sel", int'(a0), 0);
        check("reset_b_sel", int'(b0), 0);
        check("reset_shift", int'(sh0), 0);
        @(posedge clk); #1;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("ready_after_reset", int'(ready0), 1);

        // Full product, then a held DONE where start alone must be ignored.
        @(posedge clk); #1;
        issue(1'b1, s);
        run_to_valid(s + 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b1;
            mode  = 1'b0;
            #1;
            check("valid_held_without_ack", int'(valid_s), 1);
            check("start_ignored_in_done", int'(clr_s), 0);
        end
        ack_to_idle();

        // Low-half product followed by a back-to-back full product.
        issue(1'b0, s);
        run_to_valid(s + 1);
        @(posedge clk); #1;
        ack = 1'b1;
        issue(1'b1, s);
        @(posedge clk); #1;
        start = 1'b0;
        ack   = 1'b0;
        check("b2b_busy", int'(busy_s), 1);
        check("b2b_a_sel", a_s, 0);
        check("b2b_b_sel", b_s, 0);
        run_to_valid(s);
        ack_to_idle();

        // Abort in the third RUN cycle with ack and start also high.
        issue(1'b1, s);
        abort_at(3);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("no_valid_after_abort", int'(valid_s), 0);
        end

        // Small configuration.
        sel = 1'b1;
        issue(1'b1, s);
        run_to_valid(s + 1);
        ack_to_idle();
        issue(1'b0, s);
        run_to_valid(s + 1);
        ack_to_idle();

        // Randomized traffic over both instances.
        have_op = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (!have_op) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                sel = 1'($urandom_range(0, 1));
                issue(1'($urandom_range(0, 1)), s);
            end
            have_op = 1'b0;
            if ($urandom_range(0, 4) == 0) begin
                abort_at(int'($urandom_range(1, s)));
                continue;
            end
            run_to_valid(s + 1);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                check("valid_held_random", int'(valid_s), 1);
            end
            if ($urandom_range(0, 1) == 1) begin
                ack = 1'b1;
                issue(1'($urandom_range(0, 1)), s);
                have_op = 1'b1;
            end else begin
                ack_to_idle();
            end
        end
        if (have_op) begin
            run_to_valid(s + 1);
            ack_to_idle();
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("dut0_scoreboard_drained", q0.size(), 0);
        check("dut1_scoreboard_drained", q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
